sequence_counter: RTL and testbench

Timing-state generator for the basic computer's control unit: a 3-bit sequence counter with start/stop (S) flip-flop that produces the COUNT code consumed by the T0–T7 timing decoder. It advances once per clock while running, is cleared by the control logic at the end of each instruction, holds during memory stalls, and flags any lap past the terminal count as a sequencing fault.

---
 rtl/sequence_counter_pkg.sv | 8 +
 rtl/sequence_counter.sv | 91 +++++++++
 tb/tb_sequence_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sequence_counter_pkg.sv
// Shared timing-state constants for the sequence counter, timing decoder and control unit.
package sequence_counter_pkg;

   localparam int unsigned SC_WIDTH     = 3;
   localparam int unsigned SC_MAX_COUNT = 7;
   localparam logic [SC_WIDTH-1:0] SC_T0 = SC_WIDTH'(0);

endpackage

// File: rtl/sequence_counter.sv
// Sequence counter with S (run) flip-flop: produces the COUNT code for the T0..Tn decoder,
// flags each increment-driven wrap and keeps a sticky overflow until the next START.
module sequence_counter
   import sequence_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = SC_WIDTH,
   parameter int unsigned MAX_COUNT = SC_MAX_COUNT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_halt,
   input  logic             i_clr,
   input  logic             i_stall,
   output logic [WIDTH-1:0] o_count,
   output logic             o_run,
   output logic             o_wrap,
   output logic             o_ovf
);

   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] T0_C   = WIDTH'(SC_T0);
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_run;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_count_nxt;
   logic             w_run_nxt;
   logic             w_wrap_nxt;
   logic             w_ovf_nxt;
   logic             w_accept;
   logic             w_inc;

   // Next-state: HALT beats START for the run flag; accepted START, then CLR, then increment for COUNT.
   always_comb begin
      w_count_nxt = r_count;
      w_run_nxt   = r_run;
      w_wrap_nxt  = 1'b0;
      w_ovf_nxt   = r_ovf;
      w_accept    = i_start & ~r_run & ~i_halt;
      w_inc       = r_run & ~i_halt & ~i_stall;

      if (i_halt) begin
         w_run_nxt = 1'b0;
      end else if (i_start) begin
         w_run_nxt = 1'b1;
      end

      if (w_accept) begin
         w_count_nxt = T0_C;
      end else if (i_clr) begin
         w_count_nxt = T0_C;
      end else if (w_inc) begin
         if (r_count == MAX_C) begin
            w_count_nxt = T0_C;
            w_wrap_nxt  = 1'b1;
         end else begin
            w_count_nxt = r_count + ONE_C;
         end
      end

      if (w_accept) begin
         w_ovf_nxt = 1'b0;
      end else if (w_wrap_nxt) begin
         w_ovf_nxt = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= T0_C;
         r_run   <= 1'b0;
         r_wrap  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_run   <= w_run_nxt;
         r_wrap  <= w_wrap_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign o_count = r_count;
   assign o_run   = r_run;
   assign o_wrap  = r_wrap;
   assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_sequence_counter.sv
// Scoreboard bench for sequence_counter: directed scenarios plus random control traffic.
module tb_sequence_counter;
   import sequence_counter_pkg::*;

   localparam int unsigned W   = SC_WIDTH;
   localparam int          MAX = SC_MAX_COUNT;

   typedef struct {
      int cnt;
      bit run;
      bit wrap;
      bit ovf;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start, halt, clr, stall;
   logic [W-1:0] count;
   logic         run, wrap, ovf;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_cycle  = 0;

   // reference state: what the counter shows after the most recently issued edge
   int m_cnt  = 0;
   bit m_run  = 0;
   bit m_wrap = 0;
   bit m_ovf  = 0;

   sequence_counter dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_halt  (halt),
      .i_clr   (clr),
      .i_stall (stall),
      .o_count (count),
      .o_run   (run),
      .o_wrap  (wrap),
      .o_ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string name, input exp_t e);
      n_checks++;
      if (int'(count) != e.cnt || run !== e.run || wrap !== e.wrap || ovf !== e.ovf) begin
         n_fail++;
         $display("FAIL %s: got count=%0d run=%0b wrap=%0b ovf=%0b, expected count=%0d run=%0b wrap=%0b ovf=%0b",
                  name, count, run, wrap, ovf, e.cnt, e.run, e.wrap, e.ovf);
      end
   endtask

   // Behavioural rules applied to the control inputs seen at one rising edge.
   task automatic model_step(input bit s, input bit h, input bit c, input bit st);
      bit fetch;
      bit advance;
      exp_t e;
      fetch   = s && !m_run && !h;
      advance = m_run && !h && !st;
      m_wrap  = 0;
      if (fetch || c) begin
         m_cnt = 0;
      end else if (advance) begin
         m_wrap = (m_cnt + 1) > MAX;
         m_cnt  = (m_cnt + 1) % (MAX + 1);
      end
      if (fetch)       m_ovf = 0;
      else if (m_wrap) m_ovf = 1;
      m_run = h ? 1'b0 : (s ? 1'b1 : m_run);
      e.cnt = m_cnt; e.run = m_run; e.wrap = m_wrap; e.ovf = m_ovf;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit s, input bit h, input bit c, input bit st);
      @(negedge clk);
      start = s; halt = h; clr = c; stall = st;
      model_step(s, h, c, st);
   endtask

   task automatic idle_until(input int target);
      for (int i = 0; i < 20 && m_cnt != target; i++) drive(0, 0, 0, 0);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_run = 0; m_wrap = 0; m_ovf = 0;
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e.cnt = 0; e.run = 0; e.wrap = 0; e.ovf = 0;
      return e;
   endfunction

   // Monitor: every edge the DUT presents a new state; compare against the oldest expectation.
   always @(posedge clk) begin
      #1;
      n_cycle++;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         compare($sformatf("edge%0d", n_cycle), e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 0; halt = 0; clr = 0; stall = 0;
      #2;
      compare("reset_initial", reset_exp());
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // start pulse then free run across a wrap
      drive(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);

      // CLR at count 3
      idle_until(3);
      drive(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

      // STALL three cycles at count 2, then STALL+CLR
      idle_until(2);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 1, 1);

      // HALT at count 4, hold, restart clears OVF
      idle_until(4);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);

      // START+HALT from idle, then CLR at terminal count while running
      drive(0, 1, 0, 0);
      drive(1, 1, 0, 0);
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      idle_until(MAX);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);

      // asynchronous reset mid-count
      idle_until(5);
      start = 0; halt = 0; clr = 0; stall = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      compare("async_reset", reset_exp());
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);

      // random control traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 8) == 0, ($urandom % 20) == 0,
               ($urandom % 10) == 0, ($urandom % 5) == 0);
      end
      drive(0, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
